// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST session types and constants
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } bist_state_t;

    localparam int NUM_PATTERNS_DEFAULT = 16;

    // Expected MISR signature of a fault-free datapath, checked by the datapath top.
    localparam logic [31:0] GOLDEN_SIGNATURE = 32'h5A3C_96E1;

endpackage

// File: rtl/bist_session_ctrl.sv
// rtl/bist_session_ctrl.sv - BIST session sequencer: datapath reset, pattern count, pass/fail capture
module bist_session_ctrl
    import bist_pkg::*;
#(
    parameter int NUM_PATTERNS = NUM_PATTERNS_DEFAULT,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             loop_en,
    input  logic             fault_detected,
    output logic             bist_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] fail_count
);

    generate
        if (NUM_PATTERNS < 1 || NUM_PATTERNS > 255 || (NUM_PATTERNS >> CNT_W) != 0) begin : g_bad_num_patterns
            $error("bist_session_ctrl: NUM_PATTERNS out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS);

    bist_state_t      state;
    bist_state_t      next_state;
    logic [CNT_W-1:0] cnt;
    logic             sample;

    always_comb begin
        next_state = state;
        sample     = 1'b0;
        case (state)
            ST_IDLE: if (start) next_state = ST_INIT;
            ST_INIT: next_state = ST_RUN;
            ST_RUN: begin
                if (cnt == LAST_CNT) begin
                    next_state = ST_DONE;
                    sample     = 1'b1;
                end
            end
            ST_DONE: if (start || loop_en) next_state = ST_INIT;
            default: next_state = ST_IDLE;
        endcase
        // Abort overrides every other request, including the sampling edge.
        if (abort) begin
            next_state = ST_IDLE;
            sample     = 1'b0;
        end
    end

    assign busy = (state == ST_INIT) || (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bist_rst   <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_count <= '0;
        end else begin
            state    <= next_state;
            bist_rst <= (next_state != ST_RUN);
            done     <= sample;
            cnt      <= (state == ST_RUN && next_state == ST_RUN) ? cnt + CNT_W'(1) : '0;
            if (sample) begin
                fail <= fault_detected;
                pass <= ~fault_detected;
                if (fault_detected && fail_count != '1) begin
                    fail_count <= fail_count + CNT_W'(1);
                end
            end else if (next_state == ST_INIT || (abort && busy)) begin
                // A result belongs to a completed session only; abort from DONE keeps it.
                pass <= 1'b0;
                fail <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bist_session_ctrl.sv
// tb/tb_bist_session_ctrl.sv - scoreboard bench for bist_session_ctrl
module tb_bist_session_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       loop_en = 1'b0;
    logic       fault_detected = 1'b0;
    logic       bist_rst;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [7:0] fail_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       pass;
        logic       fail;
        logic [7:0] fc;
        int         cyc;
    } exp_t;

    exp_t q[$];

    bist_session_ctrl #(.NUM_PATTERNS(16), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .loop_en(loop_en),
        .fault_detected(fault_detected),
        .bist_rst(bist_rst),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fail(fail),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic p, input logic f, input int fc, input int c);
        exp_t e;
        e.pass = p;
        e.fail = f;
        e.fc   = fc[7:0];
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("scoreboard_drained", q.size(), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("pass", pass, e.pass);
                check("fail", fail, e.fail);
                check("fail_count", fail_count, e.fc);
            end
        end
    end

    initial begin
        int base;
        int n;
        int guard;

        tick(2);
        check("rst_bist_rst", bist_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_count", fail_count, 0);
        reset = 1'b0;
        tick();
        check("idle_bist_rst", bist_rst, 1);
        check("idle_busy", busy, 0);

        // Fault-free session
        start = 1'b1;
        push(1, 0, 0, cyc + 19);
        tick();
        start = 1'b0;
        check("init_busy", busy, 1);
        check("init_bist_rst", bist_rst, 1);
        tick();
        check("run_bist_rst", bist_rst, 0);
        wait_empty(40);
        check("done_bist_rst", bist_rst, 1);
        check("done_busy", busy, 0);

        // Fault present exactly at the sampling edge
        start = 1'b1;
        push(0, 1, 1, cyc + 19);
        tick();
        start = 1'b0;
        tick(17);
        fault_detected = 1'b1;
        tick();
        fault_detected = 1'b0;
        wait_empty(40);

        // Fault present only outside the sampling edge
        start = 1'b1;
        push(1, 0, 1, cyc + 19);
        tick();
        start = 1'b0;
        fault_detected = 1'b1;
        tick(16);
        fault_detected = 1'b0;
        tick(2);
        fault_detected = 1'b1;
        tick(3);
        fault_detected = 1'b0;
        wait_empty(40);

        // Abort from DONE keeps the result
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_pass", pass, 1);
        check("abort_done_fail", fail, 0);
        check("abort_done_busy", busy, 0);

        // Abort mid-RUN at cnt=5
        start = 1'b1;
        tick();
        start = 1'b0;
        check("init_clears_pass", pass, 0);
        tick(6);
        check("abort_pre_busy", busy, 1);
        check("abort_pre_bist_rst", bist_rst, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_bist_rst", bist_rst, 1);
        check("abort_pass", pass, 0);
        check("abort_fail", fail, 0);
        check("abort_done", done, 0);
        check("abort_fail_count", fail_count, 1);
        tick(25);

        // Loop mode with a permanent fault: 300 sessions, saturating count
        loop_en = 1'b1;
        fault_detected = 1'b1;
        start = 1'b1;
        base = cyc + 19;
        for (int k = 0; k < 300; k++) begin
            push(0, 1, (2 + k > 255) ? 255 : 2 + k, base + 19 * k);
        end
        tick();
        start = 1'b0;
        n = 0;
        guard = 0;
        while (n < 300 && guard < 6000) begin
            tick();
            guard++;
            if (done === 1'b1) n++;
        end
        loop_en = 1'b0;
        fault_detected = 1'b0;
        check("loop_done_count", n, 300);
        check("loop_fail_count_sat", fail_count, 255);
        wait_empty(5);
        tick(3);
        check("loop_stopped_busy", busy, 0);

        // Asynchronous reset between edges mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(5);
        #1 reset = 1'b1;
        #1;
        check("areset_bist_rst", bist_rst, 1);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_pass", pass, 0);
        check("areset_fail", fail, 0);
        check("areset_fail_count", fail_count, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_busy", busy, 0);
        start = 1'b1;
        push(1, 0, 0, cyc + 19);
        tick();
        start = 1'b0;
        wait_empty(40);

        // start held for 40 cycles: back-to-back sessions
        start = 1'b1;
        push(1, 0, 0, cyc + 19);
        push(1, 0, 0, cyc + 38);
        tick(40);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held_start_idle", busy, 0);
        wait_empty(5);
        tick(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
